// File: rtl/led_uart_pkg.sv
// Shared constants and helpers for the LED counter UART reporter.
// ASCII hex encoding and a constant-friendly ceil(log2).
package led_uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    return 8'h37 + {4'h0, nib};
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/led_uart_reporter_uart_tx.sv
// Byte serialiser: start, 8 data bits LSB first, optional parity,
// one or two stop bits; every bit lasts DIV clocks.
module uart_tx_core
  import led_uart_pkg::*;
#(
  parameter int DIV       = 10,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       done,
  output logic       tx
);

  localparam int CW = clog2(DIV);
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
  localparam logic [2:0] SB_LAST = 3'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shreg;
  logic          par;
  logic          bit_end;

  assign bit_end = (cnt == CMAX);
  assign ready   = (state == S_IDLE);
  assign done    = (state == S_STOP) && bit_end && (bitn == SB_LAST);

  // Bit sequencer; tx is registered so the line never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
    end else begin
      cnt <= (state == S_IDLE || bit_end) ? '0 : cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (valid) begin
            shreg <= data;
            par   <= (PARITY == PARITY_ODD) ? ~^data : ^data;
            state <= S_START;
            tx    <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state <= S_DATA;
            bitn  <= '0;
            tx    <= shreg[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shreg <= shreg >> 1;
            if (bitn == 3'd7) begin
              bitn <= '0;
              if (PARITY != PARITY_NONE) begin
                state <= S_PAR;
                tx    <= par;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bitn <= bitn + 1'b1;
              tx   <= shreg[1];
            end
          end
        end
        S_PAR: begin
          if (bit_end) begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (bitn == SB_LAST) state <= S_IDLE;
            else bitn <= bitn + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/led_uart_reporter.sv
// Free-running LED counter; each new value is reported on a UART
// line as ASCII hex (MSB nibble first) with optional CR LF.
module led_uart_reporter
  import led_uart_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int CNT_W       = 4,
  parameter int TICK_CYCLES = 50_000_000,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SEND_CRLF   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             hold,
  output logic [CNT_W-1:0] led,
  output logic             tx,
  output logic             busy,
  output logic             overrun
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int NCH = (CNT_W + 3) / 4;
  localparam int BW  = NCH * 4;
  localparam int PW  = (TICK_CYCLES > 1) ? clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_CYCLES - 1);
  localparam logic [1:0] IDX_TOP = 2'(NCH - 1);

  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_HEX  = 2'd1;
  localparam logic [1:0] M_CR   = 2'd2;
  localparam logic [1:0] M_LF   = 2'd3;

  logic [PW-1:0] pcnt;
  logic          wrap;
  logic          tick_q;
  logic [1:0]    mstate;
  logic          sent;
  logic [1:0]    idx;
  logic [BW-1:0] msg;
  logic [BW-1:0] msg_ext;
  logic [BW-1:0] shifted;
  logic [7:0]    byte_d;
  logic          valid;
  logic          ready;
  logic          done;
  logic          accept;

  assign wrap   = en && (pcnt == PMAX);
  assign busy   = (mstate != M_IDLE);
  assign valid  = busy && !sent;
  assign accept = valid && ready;

  // Prescaler and LED counter; tick_q marks the cycle led is new.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt   <= '0;
      led    <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= wrap;
      if (en) pcnt <= wrap ? '0 : pcnt + 1'b1;
      if (wrap) led <= led + 1'b1;
    end
  end

  // Zero-pad the counter to a whole number of nibbles.
  always_comb begin
    msg_ext = '0;
    msg_ext[CNT_W-1:0] = led;
  end

  // Snapshot, overrun flag and message sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      mstate  <= M_IDLE;
      sent    <= 1'b0;
      idx     <= '0;
      msg     <= '0;
      overrun <= 1'b0;
    end else begin
      if (tick_q && (busy || hold)) overrun <= 1'b1;
      case (mstate)
        M_IDLE: begin
          if (tick_q && !hold) begin
            msg    <= msg_ext;
            idx    <= IDX_TOP;
            sent   <= 1'b0;
            mstate <= M_HEX;
          end
        end
        M_HEX: begin
          if (done) begin
            sent <= 1'b0;
            if (idx == 2'd0)
              mstate <= (SEND_CRLF != 0) ? M_CR : M_IDLE;
            else
              idx <= idx - 1'b1;
          end else if (accept) begin
            sent <= 1'b1;
          end
        end
        M_CR: begin
          if (done) begin
            sent   <= 1'b0;
            mstate <= M_LF;
          end else if (accept) begin
            sent <= 1'b1;
          end
        end
        M_LF: begin
          if (done) begin
            sent   <= 1'b0;
            mstate <= M_IDLE;
          end else if (accept) begin
            sent <= 1'b1;
          end
        end
        default: mstate <= M_IDLE;
      endcase
    end
  end

  // Byte offered to the serialiser in the current state.
  always_comb begin
    shifted = msg >> {idx, 2'b00};
    byte_d  = hex_ascii(shifted[3:0]);
    if (mstate == M_CR) byte_d = ASCII_CR;
    else if (mstate == M_LF) byte_d = ASCII_LF;
  end

  uart_tx_core #(
    .DIV       (DIV),
    .PARITY    (PARITY),
    .STOP_BITS (STOP_BITS)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .data  (byte_d),
    .valid (valid),
    .ready (ready),
    .done  (done),
    .tx    (tx)
  );

endmodule

// File: tb/tb_led_uart_reporter.sv
// Scoreboard bench: three reporter instances with different framing,
// line decoders pop expected characters queued by the stimulus.
module tb_led_uart_reporter;

  localparam int DIV = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  logic en0, en1, en2;
  logic hold0, hold1, hold2;
  logic [7:0] led0;
  logic [3:0] led1, led2;
  logic tx0, tx1, tx2;
  logic busy0, busy1, busy2;
  logic ov0, ov1, ov2;

  logic [7:0] expq[3][$];
  int skip[3];
  logic parb[3];
  int checks = 0;
  int passes = 0;
  string hx = "0123456789ABCDEF";

  led_uart_reporter #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .CNT_W(8),
    .TICK_CYCLES(2000), .PARITY(0), .STOP_BITS(1), .SEND_CRLF(1)
  ) u0 (
    .clk(clk), .reset(rst0), .en(en0), .hold(hold0),
    .led(led0), .tx(tx0), .busy(busy0), .overrun(ov0)
  );

  led_uart_reporter #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .CNT_W(4),
    .TICK_CYCLES(200), .PARITY(1), .STOP_BITS(2), .SEND_CRLF(1)
  ) u1 (
    .clk(clk), .reset(rst1), .en(en1), .hold(hold1),
    .led(led1), .tx(tx1), .busy(busy1), .overrun(ov1)
  );

  led_uart_reporter #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .CNT_W(4),
    .TICK_CYCLES(400), .PARITY(2), .STOP_BITS(1), .SEND_CRLF(1)
  ) u2 (
    .clk(clk), .reset(rst2), .en(en2), .hold(hold2),
    .led(led2), .tx(tx2), .busy(busy2), .overrun(ov2)
  );

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] probe(input int k, input int sel);
    logic [7:0] l, b, t, o;
    case (k)
      0: begin l = led0; b = {7'd0, busy0}; t = {7'd0, tx0}; o = {7'd0, ov0}; end
      1: begin l = {4'd0, led1}; b = {7'd0, busy1}; t = {7'd0, tx1}; o = {7'd0, ov1}; end
      default: begin l = {4'd0, led2}; b = {7'd0, busy2}; t = {7'd0, tx2}; o = {7'd0, ov2}; end
    endcase
    case (sel)
      0: return l;
      1: return b;
      2: return t;
      default: return o;
    endcase
  endfunction

  function automatic logic txv(input int k);
    logic [7:0] t;
    t = probe(k, 2);
    return t[0];
  endfunction

  task automatic wait_for(input int k, input int sel, input logic [7:0] val,
                          input int bound, input string name);
    int n;
    n = 0;
    while (probe(k, sel) != val && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(name, probe(k, sel), val);
  endtask

  task automatic monitor(input int k, input int par, input int stops);
    logic [7:0] d, e;
    logic p;
    logic sok;
    forever begin
      @(negedge clk);
      if (txv(k) == 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (DIV) @(negedge clk);
          d[b] = txv(k);
        end
        p = 1'b0;
        if (par != 0) begin
          repeat (DIV) @(negedge clk);
          p = txv(k);
        end
        sok = 1'b1;
        for (int s = 0; s < stops; s++) begin
          repeat (DIV) @(negedge clk);
          if (txv(k) !== 1'b1) sok = 1'b0;
        end
        if (expq[k].size() == 0) begin
          if (skip[k] > 0) begin
            skip[k]--;
          end else begin
            checks++;
            $display("FAIL u%0d extra char: got %h expected none", k, d);
          end
        end else begin
          e = expq[k].pop_front();
          chk($sformatf("u%0d char", k), d, e);
          if (par == 1) chk($sformatf("u%0d even parity", k), p, ^e);
          if (par == 2) chk($sformatf("u%0d odd parity", k), p, ~^e);
          chk($sformatf("u%0d stop", k), sok, 1);
          if (e == 8'h42) parb[k] = p;
        end
      end
    end
  endtask

  initial begin
    rst0 = 1; rst1 = 1; rst2 = 1;
    en0 = 0; en1 = 0; en2 = 0;
    hold0 = 0; hold1 = 0; hold2 = 0;
    skip[0] = 0; skip[1] = 0; skip[2] = 0;
    parb[0] = 0; parb[1] = 1; parb[2] = 0;
    repeat (3) @(negedge clk);
    rst0 = 0; rst1 = 0; rst2 = 0;
    @(negedge clk);
    chk("reset tx", tx0, 1);
    chk("reset led", led0, 0);
    chk("reset busy", busy0, 0);
    chk("reset overrun", ov0, 0);

    fork
      monitor(0, 0, 1);
      monitor(1, 1, 2);
      monitor(2, 2, 1);
    join_none

    fork
      begin : t_u0
        int k, tlat, bc, lows, ledch;
        expq[0].push_back(hx[0]);
        expq[0].push_back(hx[1]);
        expq[0].push_back(8'h0D);
        expq[0].push_back(8'h0A);
        en0 = 1;
        wait_for(0, 0, 8'h01, 3000, "t2 first tick");
        tlat = -1; bc = 0; k = 0;
        while (k < 1000) begin
          @(negedge clk);
          k++;
          if (tx0 == 1'b0 && tlat < 0) tlat = k;
          if (busy0) bc++;
          else if (bc > 0) break;
        end
        chk("t2 start latency", tlat, 2);
        chk("t2 busy length", bc, 404);
        chk("t2 overrun", ov0, 0);

        hold0 = 1;
        wait_for(0, 0, 8'h02, 2500, "t6 hold tick");
        repeat (3) @(negedge clk);
        chk("t6 hold overrun", ov0, 1);
        chk("t6 hold busy", busy0, 0);
        lows = 0;
        repeat (300) begin
          @(negedge clk);
          if (!tx0) lows++;
        end
        chk("t6 hold line idle", lows, 0);
        hold0 = 0;

        en0 = 0;
        lows = 0; ledch = 0;
        repeat (5000) begin
          @(negedge clk);
          if (led0 != 8'h02) ledch++;
          if (!tx0) lows++;
        end
        chk("t6 en0 led frozen", ledch, 0);
        chk("t6 en0 line idle", lows, 0);
        en0 = 1;

        expq[0].push_back(hx[0]);
        skip[0] = 1;
        wait_for(0, 1, 8'h01, 2500, "t1 message start");
        repeat (150) @(negedge clk);
        rst0 = 1;
        repeat (3) @(negedge clk);
        rst0 = 0;
        @(negedge clk);
        en0 = 0;
        chk("t1 tx", tx0, 1);
        chk("t1 led", led0, 0);
        chk("t1 busy", busy0, 0);
        chk("t1 overrun", ov0, 0);
      end

      begin : t_u1
        int k, bc;
        for (int v = 1; v <= 11; v += 2) begin
          expq[1].push_back(hx[v]);
          expq[1].push_back(8'h0D);
          expq[1].push_back(8'h0A);
        end
        en1 = 1;
        wait_for(1, 1, 8'h01, 400, "t3 first busy");
        bc = 1; k = 0;
        while (k < 600) begin
          @(negedge clk);
          k++;
          if (busy1) bc++;
          else break;
        end
        chk("t3 busy length 2 stop", bc, 363);
        wait_for(1, 0, 8'h0B, 3000, "t3 reach B");
        wait_for(1, 1, 8'h01, 10, "t3 B busy");
        wait_for(1, 1, 8'h00, 500, "t3 B done");
        en1 = 0;
        chk("t5 overrun", ov1, 1);
        chk("t5 led after drop", led1, 4'hC);
        chk("t3 even parity of B", parb[1], 0);
      end

      begin : t_u2
        for (int v = 1; v <= 16; v++) begin
          expq[2].push_back(hx[v % 16]);
          expq[2].push_back(8'h0D);
          expq[2].push_back(8'h0A);
        end
        en2 = 1;
        wait_for(2, 0, 8'h0F, 7000, "t4 reach F");
        wait_for(2, 0, 8'h00, 500, "t4 wrap");
        wait_for(2, 1, 8'h01, 10, "t4 wrap busy");
        wait_for(2, 1, 8'h00, 500, "t4 wrap done");
        en2 = 0;
        chk("t4 led", led2, 0);
        chk("t4 no overrun", ov2, 0);
        chk("t3 odd parity of B", parb[2], 1);
      end
    join

    repeat (20) @(negedge clk);
    chk("u0 queue drained", expq[0].size(), 0);
    chk("u1 queue drained", expq[1].size(), 0);
    chk("u2 queue drained", expq[2].size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
